adv7513_tx_frontend: RTL
========================

Name: adv7513_tx_frontend

Overview:
Video timing generator and output stage for the ADV7513 HDMI transmitter, the transmit-side counterpart of the ADV7611 receive path. It generates the following signals from runtime timing configuration:
- active-low HSYNC/VSYNC, DE and field ID;
- pixel requests (xpos/ypos) to the framebuffer/scaler pipeline.

It registers the returned RGB and aligns it with the delayed syncs. It supports progressive and interlaced output, using the same sync phasing the receiver uses to decode FID.

Parameters:
PIXEL_LAT, 2, cycles from xpos_o/ypos_o/req_o to the corresponding R_i/G_i/B_i (1..8)

Ports:
PCLK_i  in  1  pixel clock; single clock domain
reset  in  1  asynchronous, active-high reset
enable_i  in  1  run timing; 0 holds the generator idle
H_TOTAL_i  in  12  pixels per line
H_SYNCLEN_i  in  8  HSYNC width, pixels
H_BACKPORCH_i  in  9  pixels from HSYNC start+H_SYNCLEN to first active pixel
H_ACTIVE_i  in  11  active pixels per line
V_TOTAL_i  in  11  lines per frame (both fields when interlaced)
V_SYNCLEN_i  in  4  VSYNC width, lines
V_BACKPORCH_i  in  9  lines from VSYNC start+V_SYNCLEN to first active line
V_ACTIVE_i  in  11  active lines per field (interlaced) or per frame
INTERLACED_i  in  1  1 = interlaced output
R_i, G_i, B_i  in  8 each  pixel data, valid PIXEL_LAT cycles after request
req_o  out  1  pixel request strobe (active-area pixel)
xpos_o  out  11  requested pixel column
ypos_o  out  11  requested active line within field
R_o, G_o, B_o  out  8 each  to transmitter
HSYNC_o, VSYNC_o  out  1  active-low syncs
DE_o  out  1  data enable
FID_o  out  1  0 = even field, 1 = odd field; always 1 when progressive
frame_start_o  out  1  1-cycle pulse at h=0 of the first line of each field/frame (request timing)

Behaviour:
Reset:
- All counters are 0; FID = odd.
- HSYNC_o = VSYNC_o = 1; DE_o = req_o = frame_start_o = 0.
- RGB_o, xpos_o and ypos_o are 0.
- The sync delay line is cleared to the inactive state.

Configuration latching:
- All timing inputs are latched into shadow registers at the start of each odd field/progressive frame (h=0, v=0, FID=odd) and on enable rise.
- Mid-frame changes have no effect until the next latch point.

Counters:
- h runs 0..H_TOTAL-1 and wraps; v increments at the h wrap.
- Progressive: v runs 0..V_TOTAL-1.
- Interlaced: the odd field has floor(V_TOTAL/2)+1 lines and the even field has floor(V_TOTAL/2) lines. FID toggles at each field wrap.
- Progressive: FID stays odd.

Internal sync and request timing (cycle t):
- HSYNC low while h < H_SYNCLEN.
- Odd/progressive field: VSYNC falls at h=0 of v=0 and rises at h=0 of v=V_SYNCLEN.
- Even field: VSYNC falls at h=H_TOTAL/2 (floor) of v=0 and rises at h=H_TOTAL/2 of v=V_SYNCLEN.
- hstart = H_SYNCLEN+H_BACKPORCH and vstart = V_SYNCLEN+V_BACKPORCH.
- The active area is hstart <= h < hstart+H_ACTIVE and vstart <= v < vstart+V_ACTIVE.
- If the active area exceeds H_TOTAL or the field length, it is truncated at the wrap; no aliasing into the next line.
- req_o = 1 in the active area, with xpos_o = h-hstart and ypos_o = v-vstart. Both hold their last value outside the active area.
- frame_start_o pulses when h=0 and v=0.

Output alignment:
- HSYNC, VSYNC, DE and FID pass through a shift register of PIXEL_LAT+1 stages.
- R_i/G_i/B_i are registered once.
- Result: the pixel requested at cycle t appears on R_o/G_o/B_o together with DE_o=1 at t+PIXEL_LAT+1.
- RGB_o is forced to 0 when the delayed DE is 0.

Enable:
- enable_i=0 resets the counters to h=0, v=0, FID=odd synchronously and drives the internal syncs inactive and DE/req to 0.
- The delay line keeps shifting, so outputs go idle PIXEL_LAT+1 cycles later.
- When enable_i rises, the first frame starts at h=0 on the next cycle.

Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous).

Arithmetic:
- All comparisons are unsigned at 12 bits.
- H_TOTAL < 16 or V_TOTAL < 4 is unsupported. Outputs are then unspecified, but counters must still wrap (no lockup).

Test Plan:
- 480p (H 858/62/60/720, V 525/6/30/480, prog) -> line = 858 cycles; HSYNC_o low exactly 62 cycles; 480 lines of 720 DE_o cycles; frame 450450 cycles; FID_o=1 always; VSYNC_o and HSYNC_o fall on the same cycle.
- Latency: PIXEL_LAT=2, R_i = xpos low byte delayed 2 cycles -> first DE_o cycle shows R_o=0x00, last shows 0xCF (719). DE_o first rises 3 cycles after req_o; RGB_o=0 during blanking.
- 480i (H 858/62/57/720, V_TOTAL 525, V 3/15/240, interlaced) -> fields alternate 263/262 lines. In the odd field VSYNC_o falls with HSYNC_o; in the even field it falls 429 cycles after HSYNC_o. FID_o toggles 1,0,1.
- Mid-frame change of H_ACTIVE 720->640 -> current frame keeps 720; next frame_start_o frame has 640-pixel DE.
- Overflow config: H_TOTAL=100, hstart=80, H_ACTIVE=40 -> 20 DE cycles per line; xpos_o 0..19; no DE at h 0..79 of the next line.
- enable_i low mid-line then high; reset asserted mid-frame -> outputs idle (HSYNC_o=VSYNC_o=1, DE_o=0) and restart at h=0 v=0 FID=1. Async reset clears outputs in the same cycle without a clock edge.

Source files
------------

// File: rtl/adv7513_tx_frontend.sv
// ADV7513 transmit front end: programmable video timing generator, pixel
// request interface towards the framebuffer, and an output stage that lines
// the returned RGB up with the delayed syncs. It supports progressive and
// interlaced rasters. Even fields place the VSYNC edges at mid-line so that
// the receiver can recover the field ID.
module adv7513_tx_frontend #(
  parameter int PIXEL_LAT = 2  // request-to-data latency of the pixel source, 1..8
) (
  input  logic        PCLK_i,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [11:0] H_TOTAL_i,
  input  logic [7:0]  H_SYNCLEN_i,
  input  logic [8:0]  H_BACKPORCH_i,
  input  logic [10:0] H_ACTIVE_i,
  input  logic [10:0] V_TOTAL_i,
  input  logic [3:0]  V_SYNCLEN_i,
  input  logic [8:0]  V_BACKPORCH_i,
  input  logic [10:0] V_ACTIVE_i,
  input  logic        INTERLACED_i,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  output logic        req_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic        FID_o,
  output logic        frame_start_o
);

  // Packed sync word {hsync_n, vsync_n, de, fid}; the idle value is inactive and odd.
  localparam logic [3:0] SYNC_IDLE = 4'b1101;

  // Raster position
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        fid_q, fid_d;

  // Shadow copies of the timing configuration, all widened to 12 bits
  logic [11:0] htot_q, hsl_q, hbp_q, hact_q, vtot_q, vsl_q, vbp_q, vact_q;
  logic        il_q;

  // Configuration in effect for the current cycle
  logic [11:0] htot, hsl, hbp, hact, vtot, vsl, vbp, vact;
  logic        il;
  logic        at_origin;

  // Derived timing
  logic [11:0] half, hstart, hend, vstart, vend, flen;
  logic        h_wrap, v_wrap, hs_act, vs_act, h_in, v_in, req_d, fs_d;
  logic [3:0]  s0_d, s0_q;

  // Sync delay line; entry k holds the sync word k+1 cycles after the request stage
  logic [PIXEL_LAT:0][3:0] dly_q;

  // At the origin of an odd field (or progressive frame) the live inputs are
  // used and captured, so a new configuration takes effect from the first
  // pixel. This also covers the whole disabled period, where the counters sit
  // at the origin.
  always_comb begin
    at_origin = (h_q == 12'd0) && (v_q == 12'd0) && fid_q;
    if (at_origin) begin
      htot = H_TOTAL_i;
      hsl  = {4'd0, H_SYNCLEN_i};
      hbp  = {3'd0, H_BACKPORCH_i};
      hact = {1'b0, H_ACTIVE_i};
      vtot = {1'b0, V_TOTAL_i};
      vsl  = {8'd0, V_SYNCLEN_i};
      vbp  = {3'd0, V_BACKPORCH_i};
      vact = {1'b0, V_ACTIVE_i};
      il   = INTERLACED_i;
    end else begin
      htot = htot_q;
      hsl  = hsl_q;
      hbp  = hbp_q;
      hact = hact_q;
      vtot = vtot_q;
      vsl  = vsl_q;
      vbp  = vbp_q;
      vact = vact_q;
      il   = il_q;
    end
  end

  // Raster arithmetic: window limits, field length and wrap detection.
  // Wraps use >= and treat totals of 0/1 as 1, so bad configs cannot lock up.
  always_comb begin
    half   = {1'b0, htot[11:1]};
    hstart = hsl + hbp;
    hend   = hstart + hact;
    vstart = vsl + vbp;
    vend   = vstart + vact;
    // The odd field takes the extra line of an odd V_TOTAL.
    flen   = il ? ({1'b0, vtot[11:1]} + {11'd0, fid_q}) : vtot;
    h_wrap = (htot <= 12'd1) || (h_q >= htot - 12'd1);
    v_wrap = (flen <= 12'd1) || (v_q >= flen - 12'd1);
  end

  // Next raster position; disable parks the counters at the odd-field origin.
  always_comb begin
    h_d   = h_q + 12'd1;
    v_d   = v_q;
    fid_d = fid_q;
    if (!enable_i) begin
      h_d   = 12'd0;
      v_d   = 12'd0;
      fid_d = 1'b1;
    end else if (h_wrap) begin
      h_d = 12'd0;
      if (v_wrap) begin
        v_d   = 12'd0;
        fid_d = il ? ~fid_q : 1'b1;
      end else begin
        v_d = v_q + 12'd1;
      end
    end
  end

  // Syncs and active window for the current position. Even-field VSYNC spans
  // (v=0, h=half) up to (v=vsl, h=half).
  always_comb begin
    hs_act = h_q < hsl;
    if (fid_q) begin
      vs_act = v_q < vsl;
    end else begin
      vs_act = ((v_q != 12'd0) || (h_q >= half)) &&
               ((v_q < vsl) || ((v_q == vsl) && (h_q < half)));
    end
    // Window ends are clipped by the wrap itself: h and v never reach the totals.
    h_in  = (h_q >= hstart) && (h_q < hend);
    v_in  = (v_q >= vstart) && (v_q < vend);
    req_d = enable_i && h_in && v_in;
    fs_d  = enable_i && (h_q == 12'd0) && (v_q == 12'd0);
    s0_d  = enable_i ? {~hs_act, ~vs_act, req_d, fid_q} : SYNC_IDLE;
  end

  // Raster counters and configuration shadow.
  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      h_q    <= 12'd0;
      v_q    <= 12'd0;
      fid_q  <= 1'b1;
      htot_q <= 12'd0;
      hsl_q  <= 12'd0;
      hbp_q  <= 12'd0;
      hact_q <= 12'd0;
      vtot_q <= 12'd0;
      vsl_q  <= 12'd0;
      vbp_q  <= 12'd0;
      vact_q <= 12'd0;
      il_q   <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      fid_q <= fid_d;
      if (at_origin) begin
        htot_q <= htot;
        hsl_q  <= hsl;
        hbp_q  <= hbp;
        hact_q <= hact;
        vtot_q <= vtot;
        vsl_q  <= vsl;
        vbp_q  <= vbp;
        vact_q <= vact;
        il_q   <= il;
      end
    end
  end

  // Request stage: pixel request, coordinates (held outside the window) and the
  // sync word that belongs to this request.
  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      req_o         <= 1'b0;
      xpos_o        <= 11'd0;
      ypos_o        <= 11'd0;
      frame_start_o <= 1'b0;
      s0_q          <= SYNC_IDLE;
    end else begin
      req_o         <= req_d;
      frame_start_o <= fs_d;
      s0_q          <= s0_d;
      if (req_d) begin
        xpos_o <= h_q[10:0] - hstart[10:0];
        ypos_o <= v_q[10:0] - vstart[10:0];
      end
    end
  end

  // Delay the sync word so it meets the registered pixel data.
  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      dly_q <= {(PIXEL_LAT + 1){SYNC_IDLE}};
    end else begin
      dly_q <= {dly_q[PIXEL_LAT-1:0], s0_q};
    end
  end

  // Register returned pixel data, blanked whenever the matching DE is low.
  always_ff @(posedge PCLK_i or posedge reset) begin
    if (reset) begin
      R_o <= 8'd0;
      G_o <= 8'd0;
      B_o <= 8'd0;
    end else if (dly_q[PIXEL_LAT-1][1]) begin
      R_o <= R_i;
      G_o <= G_i;
      B_o <= B_i;
    end else begin
      R_o <= 8'd0;
      G_o <= 8'd0;
      B_o <= 8'd0;
    end
  end

  assign HSYNC_o = dly_q[PIXEL_LAT][3];
  assign VSYNC_o = dly_q[PIXEL_LAT][2];
  assign DE_o    = dly_q[PIXEL_LAT][1];
  assign FID_o   = dly_q[PIXEL_LAT][0];

endmodule
